// File: rtl/rca_chunk_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rca_chunk_sequencer
// Description : W=N*K-bit add/subtract built from one N-bit ripple-carry adder
//               stepped over K chunks, LSB first, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_chunk_sequencer #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*K-1:0]   A,
  input  logic [N*K-1:0]   B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*K-1:0]   Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int W    = N * K;
  localparam int IDXW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDXW-1:0] C_LAST = IDXW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDXW-1:0]   r_idx;
  logic [W-1:0]      r_a;
  logic [W-1:0]      r_b;
  logic              r_carry;
  logic [W-1:0]      r_sum;
  logic              r_cout;
  logic              r_ovf;

  logic [N-1:0]      w_a_chunks [K];
  logic [N-1:0]      w_b_chunks [K];
  logic [N-1:0]      w_a_sel;
  logic [N-1:0]      w_b_sel;
  logic [N-1:0]      w_s;
  logic [N:0]        w_c;
  logic              w_last;

  generate
    for (genvar j = 0; j < K; j++) begin : g_chunk
      assign w_a_chunks[j] = r_a[j*N +: N];
      assign w_b_chunks[j] = r_b[j*N +: N];
    end
  endgenerate

  assign w_a_sel = w_a_chunks[r_idx];
  assign w_b_sel = w_b_chunks[r_idx];
  assign w_last  = (r_idx == C_LAST);

  // The single shared N-bit full-adder chain.
  assign w_c[0] = r_carry;
  generate
    for (genvar i = 0; i < N; i++) begin : g_fa
      assign w_s[i]   = w_a_sel[i] ^ w_b_sel[i] ^ w_c[i];
      assign w_c[i+1] = (w_a_sel[i] & w_b_sel[i]) | (w_c[i] & (w_a_sel[i] ^ w_b_sel[i]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // B is stored pre-inverted for subtract so RUN is a plain addition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_b     <= Sub ? ~B : B;
            r_carry <= Sub ? 1'b1 : Cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_carry <= w_c[N];
          r_idx   <= r_idx + IDXW'(1);
          for (int j = 0; j < K; j++) begin
            if (r_idx == IDXW'(j)) r_sum[j*N +: N] <= w_s;
          end
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= w_c[N];
            r_ovf  <= (r_a[W-1] == r_b[W-1]) & (w_s[N-1] != r_a[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign Sum       = r_sum;
  assign Cout      = r_cout;
  assign Ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rca_chunk_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_chunk_sequencer
// Description : Self-checking bench for rca_chunk_sequencer (N=8, K=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_chunk_sequencer;

  localparam int N = 8;
  localparam int K = 4;
  localparam int W = N * K;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          Cin;
  logic          Sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  Sum;
  logic          Cout;
  logic          Ovf;

  int errors = 0;
  int checks = 0;

  // Expected {Ovf, Cout, Sum}
  logic [W+1:0] sb[$];

  always #5 clk = ~clk;

  rca_chunk_sequencer #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .Cout      (Cout),
    .Ovf       (Ovf)
  );

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] be;
    logic [W:0]   r;
    logic         ovf;
    be  = sub ? ~b : b;
    r   = {1'b0, a} + {1'b0, be} + (sub ? (W+1)'(1) : (W+1)'(cin));
    ovf = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
    return {ovf, r[W], r[W-1:0]};
  endfunction

  // Entered and left at posedge+1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                      input logic sub, input logic [W+1:0] exp);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b1; A = a; B = b; Cin = cin; Sub = sub;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_in_ready: got %b want 1", in_ready);
    end
    sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; Cin = 1'($urandom_range(0, 1)); Sub = 1'($urandom_range(0, 1));
  endtask

  task automatic receive(input int stall, input string name);
    int n;
    logic [W+1:0] exp;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b after %0d edges, want 1", name, out_valid, n);
      return;
    end
    checks++;
    if (n != K) begin
      errors++;
      $display("FAIL %s_latency: got %0d edges want %0d", name, n, K);
    end
    repeat (stall) begin @(posedge clk); #1; end
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if (Sum !== exp[W-1:0]) begin
      errors++;
      $display("FAIL %s_sum: got %h want %h", name, Sum, exp[W-1:0]);
    end
    checks++;
    if (Cout !== exp[W]) begin
      errors++;
      $display("FAIL %s_cout: got %b want %b", name, Cout, exp[W]);
    end
    checks++;
    if (Ovf !== exp[W+1]) begin
      errors++;
      $display("FAIL %s_ovf: got %b want %b", name, Ovf, exp[W+1]);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_drain: out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0; Sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, Sum, Cout, Ovf, in_ready} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: out_valid=%b Sum=%h Cout=%b Ovf=%b in_ready=%b want 0/0/0/0/1",
               out_valid, Sum, Cout, Ovf, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_ripple;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0000_0000});
    receive(0, "add_wrap");
    send(32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, {1'b0, 1'b0, 32'h0000_0100});
    receive(1, "add_cin");
  endtask

  task automatic test_subtract;
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    receive(0, "sub_borrow");
  endtask

  task automatic test_overflow;
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
    receive(0, "ovf_add");
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    receive(2, "ovf_sub");
  endtask

  task automatic test_backpressure;
    logic [W-1:0] snap_sum;
    logic         snap_cout;
    logic         snap_ovf;
    logic [W+1:0] exp;
    int           n;
    int           bad;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0));
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    snap_sum = Sum; snap_cout = Cout; snap_ovf = Ovf;
    in_valid = 1'b1; A = 32'hAAAA_AAAA; B = 32'h5555_5555; Cin = 1'b1; Sub = 1'b0;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || Sum !== snap_sum ||
          Cout !== snap_cout || Ovf !== snap_ovf) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d unstable cycles want 0", bad);
    end
    exp = (sb.size() > 0) ? sb.pop_front() : '0;
    checks++;
    if ({snap_ovf, snap_cout, snap_sum} !== exp) begin
      errors++;
      $display("FAIL bp_result: got %h want %h", {snap_ovf, snap_cout, snap_sum}, exp);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_accept: in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_midop_reset;
    int seen;
    send(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0, model(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0));
    out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, Sum, Cout, Ovf, in_ready} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midrst_values: out_valid=%b Sum=%h Cout=%b Ovf=%b in_ready=%b want 0/0/0/0/1",
               out_valid, Sum, Cout, Ovf, in_ready);
    end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (K + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_valid: got %0d out_valid cycles want 0", seen);
    end
    send(32'h0000_1000, 32'h0000_0001, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0000_0FFF});
    receive(0, "midrst_next");
  endtask

  task automatic test_random;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; cin = 1'b0; sub = 1'b0; end
      send(a, b, cin, sub, model(a, b, cin, sub));
      receive(int'($urandom_range(0, 3)), "random");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_ripple();
    test_subtract();
    test_overflow();
    test_backpressure();
    test_midop_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
